instr_fetch32: RTL and testbench
================================

// Module: instr_fetch32
// PURPOSE
//  Instruction-fetch stage of the single-issue MIPS32 core; producing side of the decode32 interface.
//  Holds the PC and reads the synchronous instruction ROM (1-cycle read latency).
//  Presents instruction, PC and PC+4 (link_addr for jal) to the decoder.
//  Computes the next PC from the controller/decoder branch-jump signals.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded at reset; must be word aligned
//  ADDR_W    14             instruction ROM word-address width
// PORTS
//  clk          in   1       core clock, rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  stall        in   1       1 = hold the presented instruction; no PC update
//  imem_en      out  1       ROM read enable; high for exactly one cycle per fetch
//  imem_addr    out  ADDR_W  ROM word address = PC[ADDR_W+1:2]
//  imem_rdata   in   32      ROM data; valid the cycle after imem_en
//  instruction  out  32      instruction word to decode32
//  instr_valid  out  1       instruction/pc/link_addr are valid
//  pc           out  32      address of the presented instruction
//  link_addr    out  32      pc+4 of the presented instruction (to decode32 link_addr)
//  Branch       in   1       beq: taken when Zero=1
//  nBranch      in   1       bne: taken when Zero=0
//  Zero         in   1       ALU zero flag for the presented instruction
//  Jmp          in   1       j
//  Jal          in   1       jal
//  Jr           in   1       jr
//  sign_extend  in   32      decoder immediate (branch offset, words)
//  rdata1       in   32      decoder rs value (jr target)
//  addr_err     out  1       sticky: misaligned next-PC detected; fetch halted
// BEHAVIOUR
//  Reset (async, reset_n=0): state=S_IDLE, PC=RESET_PC, imem_en=0, instruction=0,
//   instr_valid=0, link_addr=RESET_PC+4, addr_err=0. Reset mid-fetch discards the fetch.
//  FSM:
//   S_IDLE  : imem_en=1 with imem_addr from PC -> S_FETCH (first cycle after reset release).
//   S_FETCH : latch imem_rdata into instruction, instr_valid<=1 -> S_VALID.
//   S_VALID : stall=1 -> stay; all outputs held stable, imem_en=0.
//             stall=0 -> compute NPC; if NPC[1:0]!=0 -> S_HALT;
//             else PC<=NPC, imem_en=1 (addr from NPC), instr_valid<=0 -> S_FETCH.
//   S_HALT  : addr_err=1, instr_valid=0, imem_en=0; PC keeps the faulting instruction's address;
//             exit only by reset.
//  Throughput: one instruction per 2 cycles with no stall. Redirects add no bubble.
//  NPC priority (evaluated in S_VALID, stall=0):
//   1 Jr                                 -> rdata1
//   2 Jmp|Jal                            -> {link_addr[31:28], instruction[25:0], 2'b00}
//   3 (Branch&Zero)|(nBranch&~Zero)      -> link_addr + (sign_extend<<2)
//   4 otherwise                          -> link_addr
//  Arithmetic: 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0. Upper PC bits above ADDR_W+1 are
//   truncated for imem_addr (ROM aliasing); pc/link_addr carry the full 32 bits.
//  link_addr is always pc+4, updated with pc. The controller drives Jal for the presented instruction.
//  Control inputs are sampled only in S_VALID with stall=0; they are don't-care otherwise.
//  stall asserted in S_IDLE/S_FETCH has no effect; it takes effect on reaching S_VALID.
// TESTING
//  T1 reset_n low then high, RESET_PC=0, ROM[0]=32'h0043_3820 -> imem_en pulse with addr 0,
//     2 cycles later instr_valid=1, instruction=32'h0043_3820, pc=0, link_addr=4.
//  T2 Sequential, no control, 3 instructions -> pc 0,4,8; instr_valid high every 2nd cycle.
//  T3 pc=0x10, Branch=1, Zero=1, sign_extend=32'hFFFF_FFFC -> next pc=0x04.
//     Same with Zero=0 -> next pc=0x14.
//     nBranch=1, Zero=0 -> taken.
//  T4 pc=0x18, Jal=1, instruction=32'h0C00_0040 -> link_addr=0x1C while presented; next pc=0x100.
//     Jr=1, rdata1=0x1C -> next pc=0x1C.
//  T5 stall=1 for 5 cycles in S_VALID -> instruction/pc/link_addr unchanged, imem_en=0.
//     After stall release, fetch resumes with one imem_en pulse.
//  T6 Jr=1, rdata1=0x0000_0102 -> addr_err=1, instr_valid=0, no imem_en.
//     reset_n pulse mid-S_FETCH -> all outputs at reset values; fetch restarts from RESET_PC.

Source files
------------

// File: rtl/instr_fetch32_if.sv
// Fetch-to-decode bundle for instr_fetch32: instruction ROM port, decoder-facing outputs,
// branch/jump controls and an FSM state debug tap.
interface instr_fetch32_if #(
    parameter int ADDR_W = 14
);
    // Handshake: instr_valid is the valid. stall is an inverted ready. An instruction is
    // consumed on a cycle with instr_valid=1 and stall=0. While it waits it is held stable.
    logic              stall;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       instruction;
    logic              instr_valid;
    logic [31:0]       pc;
    logic [31:0]       link_addr;
    logic              Branch;
    logic              nBranch;
    logic              Zero;
    logic              Jmp;
    logic              Jal;
    logic              Jr;
    logic [31:0]       sign_extend;
    logic [31:0]       rdata1;
    logic              addr_err;
    logic [1:0]        state_dbg;

    modport master (
        input  stall, imem_rdata, Branch, nBranch, Zero, Jmp, Jal, Jr, sign_extend, rdata1,
        output imem_en, imem_addr, instruction, instr_valid, pc, link_addr, addr_err, state_dbg
    );

    modport slave (
        output stall, imem_rdata, Branch, nBranch, Zero, Jmp, Jal, Jr, sign_extend, rdata1,
        input  imem_en, imem_addr, instruction, instr_valid, pc, link_addr, addr_err, state_dbg
    );
endinterface

// File: rtl/instr_fetch32.sv
// MIPS32 instruction-fetch stage: holds the PC, reads a 1-cycle synchronous ROM and
// selects the next PC from the branch/jump controls of the presented instruction.
module instr_fetch32 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 14
) (
    input  logic           clk,
    input  logic           reset_n,
    instr_fetch32_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] link_addr;
    logic [31:0] npc;
    logic [31:0] fetch_addr;
    logic        br_taken;
    logic        fetch_go;
    logic        unused_addr_bits;

    assign link_addr = pc_q + 32'd4;
    assign br_taken  = (bus.Branch & bus.Zero) | (bus.nBranch & ~bus.Zero);

    always_comb begin
        npc = link_addr;
        if (bus.Jr) begin
            npc = bus.rdata1;
        end else if (bus.Jmp | bus.Jal) begin
            npc = {link_addr[31:28], instr_q[25:0], 2'b00};
        end else if (br_taken) begin
            npc = link_addr + (bus.sign_extend << 2);
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        addr_err_d = addr_err_q;
        fetch_go   = 1'b0;
        fetch_addr = pc_q;
        case (state_q)
            S_IDLE: begin
                fetch_go = 1'b1;
                state_d  = S_FETCH;
            end
            S_FETCH: begin
                instr_d = bus.imem_rdata;
                valid_d = 1'b1;
                state_d = S_VALID;
            end
            S_VALID: begin
                if (!bus.stall) begin
                    valid_d = 1'b0;
                    if (npc[1:0] != 2'b00) begin
                        // PC stays on the faulting instruction so software can inspect it.
                        addr_err_d = 1'b1;
                        state_d    = S_HALT;
                    end else begin
                        pc_d       = npc;
                        fetch_go   = 1'b1;
                        fetch_addr = npc;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                valid_d    = 1'b0;
                addr_err_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            valid_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    // S_IDLE is the reset state, so the read enable is masked while reset is held.
    assign bus.imem_en     = fetch_go & reset_n;
    assign bus.imem_addr   = fetch_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.link_addr   = link_addr;
    assign bus.addr_err    = addr_err_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_instr_fetch32.sv
// Directed bench for instr_fetch32: reset, sequential fetch, branches, jumps,
// stall hold, misaligned-target halt and reset during a fetch.
module tb_instr_fetch32;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch32_if #(.ADDR_W(14)) bus ();

    instr_fetch32 #(.RESET_PC(32'h0000_0000), .ADDR_W(14)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Synchronous ROM model, aliased on the low 8 word-address bits.
    logic [31:0] rom [0:255];
    always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= rom[bus.imem_addr[7:0]];

    task automatic set_ctrl(input logic jr, input logic jmp, input logic jal, input logic br,
                            input logic nbr, input logic zero, input logic [31:0] se,
                            input logic [31:0] rd1);
        bus.Jr = jr; bus.Jmp = jmp; bus.Jal = jal; bus.Branch = br;
        bus.nBranch = nbr; bus.Zero = zero; bus.sign_extend = se; bus.rdata1 = rd1;
    endtask

    task automatic clear_ctrl();
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Advances to the next presented instruction; cycles = -1 if it never shows up.
    task automatic next_instr(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            clear_ctrl();
            cycles++;
        end while (!bus.instr_valid && cycles < 8);
        if (!bus.instr_valid) cycles = -1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.stall = 1'b0;
        clear_ctrl();
        repeat (2) @(negedge clk);
        n_checks++; if (bus.imem_en !== 1'b0) begin n_fail++; $display("FAIL rst_imem_en: got %b want 0", bus.imem_en); end
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid); end
        n_checks++; if (bus.instruction !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", bus.instruction); end
        n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", bus.pc); end
        n_checks++; if (bus.link_addr !== 32'h4) begin n_fail++; $display("FAIL rst_link: got %h want 4", bus.link_addr); end
        n_checks++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL rst_addr_err: got %b want 0", bus.addr_err); end
        n_checks++; if (bus.state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", bus.state_dbg); end
        reset_n = 1'b1;
        #1;
        n_checks++; if (bus.imem_en !== 1'b1) begin n_fail++; $display("FAIL t1_imem_en: got %b want 1", bus.imem_en); end
        n_checks++; if (bus.imem_addr !== 14'd0) begin n_fail++; $display("FAIL t1_imem_addr: got %h want 0", bus.imem_addr); end
        @(negedge clk);
        n_checks++; if (bus.state_dbg !== 2'd1) begin n_fail++; $display("FAIL t1_state_fetch: got %0d want 1", bus.state_dbg); end
        n_checks++; if (bus.imem_en !== 1'b0) begin n_fail++; $display("FAIL t1_en_single: got %b want 0", bus.imem_en); end
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_early: got %b want 0", bus.instr_valid); end
        @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid: got %b want 1", bus.instr_valid); end
        n_checks++; if (bus.instruction !== 32'h0043_3820) begin n_fail++; $display("FAIL t1_instr: got %h want 00433820", bus.instruction); end
        n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL t1_pc: got %h want 0", bus.pc); end
        n_checks++; if (bus.link_addr !== 32'h4) begin n_fail++; $display("FAIL t1_link: got %h want 4", bus.link_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [2]    = '{32'h4, 32'h8};
        logic [31:0] exp_instr [2] = '{32'hA500_0001, 32'hA500_0002};
        logic [13:0] exp_addr [2]  = '{14'd1, 14'd2};
        int cyc;
        for (int i = 0; i < 2; i++) begin
            clear_ctrl();
            #1;
            n_checks++; if (bus.imem_en !== 1'b1) begin n_fail++; $display("FAIL seq_en[%0d]: got %b want 1", i, bus.imem_en); end
            n_checks++; if (bus.imem_addr !== exp_addr[i]) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h want %h", i, bus.imem_addr, exp_addr[i]); end
            next_instr(cyc);
            n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL seq_cycles[%0d]: got %0d want 2", i, cyc); end
            n_checks++; if (bus.pc !== exp_pc[i]) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pc, exp_pc[i]); end
            n_checks++; if (bus.instruction !== exp_instr[i]) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h want %h", i, bus.instruction, exp_instr[i]); end
            n_checks++; if (bus.link_addr !== exp_pc[i] + 32'd4) begin n_fail++; $display("FAIL seq_link[%0d]: got %h want %h", i, bus.link_addr, exp_pc[i] + 32'd4); end
        end
    endtask

    task automatic test_branch();
        int cyc;
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h10);
        #1;
        n_checks++; if (bus.imem_addr !== 14'd4) begin n_fail++; $display("FAIL jr_addr: got %h want 4", bus.imem_addr); end
        next_instr(cyc);
        n_checks++; if (bus.pc !== 32'h10) begin n_fail++; $display("FAIL jr_pc: got %h want 10", bus.pc); end
        n_checks++; if (bus.instruction !== 32'hA500_0004) begin n_fail++; $display("FAIL jr_instr: got %h want a5000004", bus.instruction); end
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
        #1;
        n_checks++; if (bus.imem_addr !== 14'd1) begin n_fail++; $display("FAIL beq_taken_addr: got %h want 1", bus.imem_addr); end
        next_instr(cyc);
        n_checks++; if (bus.pc !== 32'h4) begin n_fail++; $display("FAIL beq_taken_pc: got %h want 4", bus.pc); end
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h10);
        next_instr(cyc);
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);
        next_instr(cyc);
        n_checks++; if (bus.pc !== 32'h14) begin n_fail++; $display("FAIL beq_not_taken_pc: got %h want 14", bus.pc); end
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2, 32'h0);
        next_instr(cyc);
        n_checks++; if (bus.pc !== 32'h20) begin n_fail++; $display("FAIL bne_taken_pc: got %h want 20", bus.pc); end
        n_checks++; if (bus.instruction !== 32'hA500_0008) begin n_fail++; $display("FAIL bne_taken_instr: got %h want a5000008", bus.instruction); end
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2, 32'h0);
        next_instr(cyc);
        n_checks++; if (bus.pc !== 32'h24) begin n_fail++; $display("FAIL bne_not_taken_pc: got %h want 24", bus.pc); end
    endtask

    task automatic test_jump();
        int cyc;
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h18);
        next_instr(cyc);
        n_checks++; if (bus.instruction !== 32'h0C00_0040) begin n_fail++; $display("FAIL jal_instr: got %h want 0c000040", bus.instruction); end
        n_checks++; if (bus.link_addr !== 32'h1C) begin n_fail++; $display("FAIL jal_link: got %h want 1c", bus.link_addr); end
        set_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        n_checks++; if (bus.imem_addr !== 14'h40) begin n_fail++; $display("FAIL jal_addr: got %h want 40", bus.imem_addr); end
        next_instr(cyc);
        n_checks++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL jal_pc: got %h want 100", bus.pc); end
        n_checks++; if (bus.instruction !== 32'hA500_0040) begin n_fail++; $display("FAIL jal_target_instr: got %h want a5000040", bus.instruction); end
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1C);
        next_instr(cyc);
        n_checks++; if (bus.pc !== 32'h1C) begin n_fail++; $display("FAIL jr_return_pc: got %h want 1c", bus.pc); end
        // Jr beats Jmp beats a taken branch.
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h20);
        next_instr(cyc);
        n_checks++; if (bus.pc !== 32'h20) begin n_fail++; $display("FAIL prio_jr_pc: got %h want 20", bus.pc); end
        set_ctrl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
        #1;
        n_checks++; if (bus.imem_addr !== 14'h0008) begin n_fail++; $display("FAIL prio_jmp_addr: got %h want 0008", bus.imem_addr); end
        next_instr(cyc);
        n_checks++; if (bus.pc !== 32'h0400_0020) begin n_fail++; $display("FAIL prio_jmp_pc: got %h want 04000020", bus.pc); end
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
        #1;
        n_checks++; if (bus.imem_addr !== 14'h3FFF) begin n_fail++; $display("FAIL alias_addr: got %h want 3fff", bus.imem_addr); end
        next_instr(cyc);
        n_checks++; if (bus.link_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_link: got %h want 0", bus.link_addr); end
        n_checks++; if (bus.instruction !== 32'hA500_00FF) begin n_fail++; $display("FAIL alias_instr: got %h want a50000ff", bus.instruction); end
        next_instr(cyc);
        n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 0", bus.pc); end
        n_checks++; if (bus.instruction !== 32'h0043_3820) begin n_fail++; $display("FAIL wrap_instr: got %h want 00433820", bus.instruction); end
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8000_0010);
        next_instr(cyc);
        set_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        next_instr(cyc);
        n_checks++; if (bus.pc !== 32'h8400_0010) begin n_fail++; $display("FAIL jmp_region_pc: got %h want 84000010", bus.pc); end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0102);
        #1;
        n_checks++; if (bus.imem_en !== 1'b0) begin n_fail++; $display("FAIL stall_en0: got %b want 0", bus.imem_en); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_checks++; if (bus.pc !== 32'h8400_0010) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 84000010", i, bus.pc); end
            n_checks++; if (bus.link_addr !== 32'h8400_0014) begin n_fail++; $display("FAIL stall_link[%0d]: got %h want 84000014", i, bus.link_addr); end
            n_checks++; if (bus.instruction !== 32'hA500_0004) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want a5000004", i, bus.instruction); end
            n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, bus.instr_valid); end
            n_checks++; if (bus.imem_en !== 1'b0) begin n_fail++; $display("FAIL stall_en[%0d]: got %b want 0", i, bus.imem_en); end
        end
        @(negedge clk);
        bus.stall = 1'b0;
        clear_ctrl();
        #1;
        n_checks++; if (bus.imem_en !== 1'b1) begin n_fail++; $display("FAIL unstall_en: got %b want 1", bus.imem_en); end
        n_checks++; if (bus.imem_addr !== 14'h0005) begin n_fail++; $display("FAIL unstall_addr: got %h want 0005", bus.imem_addr); end
        @(negedge clk);
        bus.stall = 1'b1;
        #1;
        n_checks++; if (bus.imem_en !== 1'b0) begin n_fail++; $display("FAIL unstall_single_pulse: got %b want 0", bus.imem_en); end
        @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_in_fetch_valid: got %b want 1", bus.instr_valid); end
        n_checks++; if (bus.pc !== 32'h8400_0014) begin n_fail++; $display("FAIL stall_in_fetch_pc: got %h want 84000014", bus.pc); end
        n_checks++; if (bus.instruction !== 32'hA500_0005) begin n_fail++; $display("FAIL stall_in_fetch_instr: got %h want a5000005", bus.instruction); end
        bus.stall = 1'b0;
    endtask

    task automatic test_addr_err();
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0102);
        #1;
        n_checks++; if (bus.imem_en !== 1'b0) begin n_fail++; $display("FAIL misalign_en: got %b want 0", bus.imem_en); end
        @(negedge clk);
        clear_ctrl();
        n_checks++; if (bus.addr_err !== 1'b1) begin n_fail++; $display("FAIL misalign_err: got %b want 1", bus.addr_err); end
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL misalign_valid: got %b want 0", bus.instr_valid); end
        n_checks++; if (bus.pc !== 32'h8400_0014) begin n_fail++; $display("FAIL misalign_pc: got %h want 84000014", bus.pc); end
        n_checks++; if (bus.state_dbg !== 2'd3) begin n_fail++; $display("FAIL misalign_state: got %0d want 3", bus.state_dbg); end
        repeat (3) @(negedge clk);
        n_checks++; if (bus.addr_err !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b want 1", bus.addr_err); end
        n_checks++; if (bus.imem_en !== 1'b0) begin n_fail++; $display("FAIL halt_en: got %b want 0", bus.imem_en); end
    endtask

    task automatic test_reset_mid_fetch();
        int cyc;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.state_dbg !== 2'd1) begin n_fail++; $display("FAIL mid_state_fetch: got %0d want 1", bus.state_dbg); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.state_dbg !== 2'd0) begin n_fail++; $display("FAIL mid_rst_state: got %0d want 0", bus.state_dbg); end
        n_checks++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err: got %b want 0", bus.addr_err); end
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", bus.instr_valid); end
        n_checks++; if (bus.imem_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_en: got %b want 0", bus.imem_en); end
        n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL mid_rst_pc: got %h want 0", bus.pc); end
        n_checks++; if (bus.link_addr !== 32'h4) begin n_fail++; $display("FAIL mid_rst_link: got %h want 4", bus.link_addr); end
        n_checks++; if (bus.instruction !== 32'h0) begin n_fail++; $display("FAIL mid_rst_instr: got %h want 0", bus.instruction); end
        @(negedge clk);
        reset_n = 1'b1;
        next_instr(cyc);
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL restart_cycles: got %0d want 2", cyc); end
        n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL restart_pc: got %h want 0", bus.pc); end
        n_checks++; if (bus.instruction !== 32'h0043_3820) begin n_fail++; $display("FAIL restart_instr: got %h want 00433820", bus.instruction); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'hA500_0000 | i;
        rom[0] = 32'h0043_3820;
        rom[6] = 32'h0C00_0040;
        bus.imem_rdata = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_addr_err();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
